// File: rtl/vga_pkg.sv
// Shared definitions for the bouncing-box pattern generator: colours,
// default resolution, FSM encoding and the per-axis move rule.
package vga_pkg;

  localparam int H_RES_DEF    = 640;
  localparam int V_RES_DEF    = 480;
  localparam int BOX_SIZE_DEF = 32;

  // All position arithmetic runs at this width so x+step can never wrap.
  localparam int POS_W = 11;

  localparam logic [2:0] BG_RGB  = 3'b001;
  localparam logic [2:0] BOX_RGB = 3'b110;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_MOVE_X = 2'd1,
    S_MOVE_Y = 2'd2
  } state_e;

  typedef logic [POS_W-1:0] pos_t;

  typedef struct packed {
    pos_t pos;
    logic dir;
  } axis_t;

  // One step along an axis; dir=1 moves up-count, clamping and flipping at
  // either end so the box never leaves [0, lim].
  function automatic axis_t axis_step(pos_t pos, logic dir, pos_t step, pos_t lim);
    axis_t r;
    r.pos = pos;
    r.dir = dir;
    if (dir) begin
      if (pos + step >= lim) begin
        r.pos = lim;
        r.dir = 1'b0;
      end else begin
        r.pos = pos + step;
      end
    end else begin
      if (pos <= step) begin
        r.pos = '0;
        r.dir = 1'b1;
      end else begin
        r.pos = pos - step;
      end
    end
    return r;
  endfunction

  // Colour sequence used on bounces: increment, skipping black.
  function automatic logic [2:0] colour_next(logic [2:0] c);
    return (c == 3'b111) ? 3'b001 : c + 3'd1;
  endfunction

endpackage

// File: rtl/bounce_box_gen_if.sv
// Pixel bus between the VGA timing driver and the pattern generator.
// The driver (master) supplies the scan position and vertical sync and
// receives the pixel colour back.
interface bounce_box_gen_if;
  logic [8:0] row;
  logic [9:0] column;
  logic       vsync;
  logic [2:0] rgb;

  modport master (output row, output column, output vsync, input rgb);
  modport slave  (input row, input column, input vsync, output rgb);
endinterface

// File: rtl/bounce_box_gen_render.sv
// Pixel renderer: registers the colour for the current scan position,
// box colour inside the box square, background elsewhere.
module bounce_box_gen_render
  import vga_pkg::*;
#(
  parameter int BOX_SIZE = BOX_SIZE_DEF
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  bounce_box_gen_if.slave         pix,
  input  logic [9:0]              x_i,
  input  logic [8:0]              y_i,
  input  logic [2:0]              box_rgb_i
);

  localparam pos_t BOX_W = pos_t'(BOX_SIZE);

  pos_t       col_w;
  pos_t       row_w;
  pos_t       x_w;
  pos_t       y_w;
  logic       in_box;
  logic [2:0] rgb_d;
  logic [2:0] rgb_q;

  // Box hit test, widened so x+BOX_SIZE cannot wrap at the right edge.
  always_comb begin
    col_w  = pos_t'(pix.column);
    row_w  = pos_t'(pix.row);
    x_w    = pos_t'(x_i);
    y_w    = pos_t'(y_i);
    in_box = (col_w >= x_w) && (col_w < x_w + BOX_W) &&
             (row_w >= y_w) && (row_w < y_w + BOX_W);
    rgb_d  = in_box ? box_rgb_i : BG_RGB;
  end

  // Output colour register; black while in reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rgb_q <= 3'b000;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign pix.rgb = rgb_q;

endmodule

// File: rtl/vsync_edge_det.sv
// Falling-edge detector for the active-low vertical sync. The input is
// registered twice; both stages come out of reset high so the very first
// sample after reset can never look like a falling edge.
module vsync_edge_det (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sig_i,
  output logic fall_o
);

  logic sig_q;
  logic sig_prev_q;

  // Sample the sync and keep the previous sample for edge comparison.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sig_q      <= 1'b1;
      sig_prev_q <= 1'b1;
    end else begin
      sig_q      <= sig_i;
      sig_prev_q <= sig_q;
    end
  end

  assign fall_o = sig_prev_q & ~sig_q;

endmodule

// File: rtl/bounce_box_gen.sv
// Bouncing-box test pattern generator. Once per frame (vSync fall, unless
// paused) the box moves one or two pixels along x, then along y, reversing
// direction at the screen edges.
// Build option: COLOR_CYCLE_EN -- when defined, the box colour steps on
// every bounce; otherwise it stays at BOX_RGB.
//
// state    | meaning
// S_WAIT   | idle, waiting for a frame tick with pause low
// S_MOVE_X | apply one step to x/dx
// S_MOVE_Y | apply one step to y/dy, then back to idle
module bounce_box_gen
  import vga_pkg::*;
#(
  parameter int H_RES    = H_RES_DEF,
  parameter int V_RES    = V_RES_DEF,
  parameter int BOX_SIZE = BOX_SIZE_DEF
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [8:0] row_i,
  input  logic [9:0] column_i,
  input  logic       vSync_i,
  input  logic       pause_i,
  input  logic       speed_i,
  output logic [2:0] rgb_o
);

  localparam pos_t X_MAX = pos_t'(H_RES - BOX_SIZE);
  localparam pos_t Y_MAX = pos_t'(V_RES - BOX_SIZE);

  bounce_box_gen_if pix_bus ();

  assign pix_bus.row    = row_i;
  assign pix_bus.column = column_i;
  assign pix_bus.vsync  = vSync_i;
  assign rgb_o          = pix_bus.rgb;

  logic frame_tick;

  vsync_edge_det u_vsync_edge (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .sig_i   (pix_bus.vsync),
    .fall_o  (frame_tick)
  );

  state_e     state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       dx_q, dx_d;
  logic       dy_q, dy_d;
  pos_t       step;
  axis_t      x_upd;
  axis_t      y_upd;
  logic [2:0] box_rgb;

  // Next-state logic: a frame tick is only honoured in S_WAIT, so ticks
  // arriving mid-move are dropped rather than queued.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    step    = speed_i ? pos_t'(2) : pos_t'(1);
    x_upd   = axis_step(pos_t'(x_q), dx_q, step, X_MAX);
    y_upd   = axis_step(pos_t'(y_q), dy_q, step, Y_MAX);
    unique case (state_q)
      S_WAIT: begin
        if (frame_tick && !pause_i) begin
          state_d = S_MOVE_X;
        end
      end
      S_MOVE_X: begin
        x_d     = 10'(x_upd.pos);
        dx_d    = x_upd.dir;
        state_d = S_MOVE_Y;
      end
      S_MOVE_Y: begin
        y_d     = 9'(y_upd.pos);
        dy_d    = y_upd.dir;
        state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  // State and position registers; reset wins over any move in progress.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_WAIT;
      x_q     <= '0;
      y_q     <= '0;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
    end
  end

`ifdef COLOR_CYCLE_EN
  logic [2:0] box_rgb_q, box_rgb_d;

  // Each move state can bounce once, so a corner hit steps the colour twice.
  always_comb begin
    box_rgb_d = box_rgb_q;
    if ((state_q == S_MOVE_X && x_upd.dir != dx_q) ||
        (state_q == S_MOVE_Y && y_upd.dir != dy_q)) begin
      box_rgb_d = colour_next(box_rgb_q);
    end
  end

  // Box colour register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      box_rgb_q <= BOX_RGB;
    end else begin
      box_rgb_q <= box_rgb_d;
    end
  end

  assign box_rgb = box_rgb_q;
`else
  assign box_rgb = BOX_RGB;
`endif

  bounce_box_gen_render #(
    .BOX_SIZE (BOX_SIZE)
  ) u_render (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .pix       (pix_bus.slave),
    .x_i       (x_q),
    .y_i       (y_q),
    .box_rgb_i (box_rgb)
  );

endmodule

// File: doc/bounce_box_gen.md
BOUNCE_BOX_GEN -- requirements
Module: bounce_box_gen

Interface
REQ-001 SHALL have parameter: H_RES, 640, visible columns.
REQ-002 SHALL have parameter: V_RES, 480, visible rows.
REQ-003 SHALL have parameter: BOX_SIZE, 32, box edge length in pixels.
REQ-004 SHALL have port: clk_i  input  1  system clock, 50MHz.
REQ-005 SHALL have port: reset_i  input  1  reset; synchronous, active-high, one clock.
REQ-006 SHALL have port: row_i  input  9  current pixel row, from the VGA driver.
REQ-007 SHALL have port: column_i  input  10  current pixel column, from the VGA driver.
REQ-008 SHALL have port: vSync_i  input  1  vertical sync from the VGA driver, active-low pulse.
REQ-009 SHALL have port: pause_i  input  1  1 = freeze box motion.
REQ-010 SHALL have port: speed_i  input  1  0 = 1 px/frame, 1 = 2 px/frame.
REQ-011 SHALL have port: rgb_o  output  3  pixel colour to the VGA driver; [2] R, [1] G, [0] B.

Function
REQ-012 SHALL hold box position x (10 bit), y (9 bit) and direction bits dx (1 = right), dy (1 = down).
REQ-013 SHALL register rgb_o with 1-cycle latency from row_i/column_i.
- Box colour when x <= column_i < x+BOX_SIZE and y <= row_i < y+BOX_SIZE.
- BG_RGB (3'b001) otherwise.
REQ-014 SHALL generate frame_tick on every 1->0 edge of registered vSync_i.
- Single cycle.
- First sample after reset counts as 1, so no tick fires on the first cycle.
REQ-015 SHALL run FSM states S_WAIT, S_MOVE_X, S_MOVE_Y.
- S_WAIT -> S_MOVE_X on frame_tick with pause_i=0.
- S_MOVE_X -> S_MOVE_Y unconditionally.
- S_MOVE_Y -> S_WAIT unconditionally.
REQ-016 SHALL, in S_MOVE_X, update x by step = speed_i ? 2 : 1, as follows.
- dx=1 and x+step >= H_RES-BOX_SIZE: x = H_RES-BOX_SIZE, dx = 0.
- dx=0 and x <= step: x = 0, dx = 1.
- Otherwise: x +/- step.
REQ-017 SHALL apply the same rule to y in S_MOVE_Y, using V_RES and dy.
REQ-018 SHALL sample speed_i in each move state; pause_i is sampled only in S_WAIT.
REQ-019 SHALL ignore frame_tick while not in S_WAIT; it is not queued.
REQ-020 SHALL perform all arithmetic 11 bits wide, with no wrap-around.
- x SHALL never exceed H_RES-BOX_SIZE.
- y SHALL never exceed V_RES-BOX_SIZE.
REQ-021 SHALL treat a bounce as a direction bit changing in either move state.

Reset
REQ-022 SHALL set the following on reset_i=1 at a clock edge: x=0, y=0, dx=1, dy=1, FSM=S_WAIT, rgb_o=3'b000, box colour=BOX_RGB (3'b110), vSync register=1.
REQ-023 SHALL have reset asserted mid-move abort the move, with no partial update retained.

Configuration
REQ-024 SHALL, with COLOR_CYCLE_EN defined, advance the box colour on every bounce.
- Sequence: 3'b110 -> 3'b111 -> 3'b001 ... wrapping 3'b111 -> 3'b001 (i.e. increment, skipping 3'b000).
- If both axes bounce in one frame, the colour advances twice.
REQ-025 SHALL, without COLOR_CYCLE_EN, keep the box colour constant at BOX_RGB.

Structure
REQ-026 SHALL place BG_RGB, BOX_RGB, the FSM state encoding and default H_RES/V_RES in shared package vga_pkg.
REQ-027 SHALL implement the vSync falling-edge detection as sub-module vsync_edge_det (ports clk_i, reset_i, sig_i, fall_o).

Verification
REQ-028 SHALL cover reset: after reset, row_i=0, column_i=0 -> rgb_o=3'b110 next cycle; column_i=32 -> rgb_o=3'b001.
REQ-029 SHALL cover motion: speed_i=0, one vSync_i fall -> x=1, y=1 within 3 cycles; speed_i=1, next fall -> x=3, y=3.
REQ-030 SHALL cover the right bounce: x=607, dx=1, speed_i=1, tick -> x=608, dx=0; next tick -> x=606.
REQ-031 SHALL cover the top-left corner: x=1, y=1, dx=0, dy=0, speed_i=1, tick -> x=0, y=0, dx=1, dy=1; with COLOR_CYCLE_EN, colour 3'b110 -> 3'b001.
REQ-032 SHALL cover pause: pause_i=1 across 3 vSync falls -> x, y unchanged; pause_i=0 -> motion resumes on the next fall.
REQ-033 SHALL cover reset in state: reset_i pulsed while in S_MOVE_X -> x=0, y=0, S_WAIT, rgb_o=3'b000 next cycle.
